// File: rtl/converge_monitor_if.sv
// Bundles the convergence monitor's control, channel and verdict signals.
// The bench/driver takes the master side; the monitor takes the slave side.
interface converge_monitor_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 2
);
    logic                      start;
    logic                      abort;
    logic [WIDTH-1:0]          target;
    logic [NUM_CH*WIDTH-1:0]   ch;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [1:0]                fail_code;
    logic [31:0]               settle_at;
    logic [WIDTH:0]            max_dev;

    modport master (
        output start, abort, target, ch,
        input  busy, done, pass, fail_code, settle_at, max_dev
    );

    modport slave (
        input  start, abort, target, ch,
        output busy, done, pass, fail_code, settle_at, max_dev
    );
endinterface

// File: rtl/converge_monitor.sv
// Windowed multi-channel settling checker: reports pass once every channel has stayed near
// target (and ch0/ch1 near each other) for SETTLE_CYC consecutive cycles, else times out.
module converge_monitor #(
    parameter int          WIDTH       = 16,
    parameter int          NUM_CH      = 2,
    parameter int unsigned TOL         = 250,
    parameter int unsigned DIFF_TOL    = 5,
    parameter int unsigned SETTLE_CYC  = 1024,
    parameter int unsigned TIMEOUT_CYC = 20000000
) (
    input  logic              clk,
    input  logic              rst_n,
    converge_monitor_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [WIDTH:0] L_TOL      = (WIDTH+1)'(TOL);
    localparam logic [WIDTH:0] L_DIFF_TOL = (WIDTH+1)'(DIFF_TOL);
    localparam logic [31:0]    L_SET      = 32'(SETTLE_CYC);
    localparam logic [31:0]    L_SET_M1   = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]    L_TMO      = 32'(TIMEOUT_CYC);
    localparam logic [31:0]    L_TMO_M1   = 32'(TIMEOUT_CYC - 1);

    // Sign-extend both operands one bit so the difference can never overflow.
    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (d[WIDTH]) begin
            abs_diff = (~d) + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_diff = d;
        end
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_target;
    logic [31:0]      r_win_cnt;
    logic [31:0]      r_tmo_cnt;
    logic [31:0]      r_settle_at;
    logic [WIDTH:0]   r_max_dev;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [1:0]       r_fail_code;
    logic             r_diff_only;

    logic [WIDTH:0]   w_abs [NUM_CH];
    logic [WIDTH:0]   w_peak;
    logic [WIDTH:0]   w_diff_abs;
    logic [WIDTH:0]   w_new_max;
    logic             w_chan_ok;
    logic             w_diff_ok;
    logic             w_in_win;
    logic [1:0]       w_tmo_code;

    // Per-channel deviation magnitude from the latched target.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_abs[i] = abs_diff(bus.ch[i*WIDTH +: WIDTH], r_target);
        end
    end

    // Window decision, peak deviation and the timeout cause code.
    always_comb begin
        w_chan_ok = 1'b1;
        w_peak    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_chan_ok = w_chan_ok & (w_abs[i] <= L_TOL);
            w_peak    = (w_abs[i] > w_peak) ? w_abs[i] : w_peak;
        end
        w_diff_abs = abs_diff(bus.ch[0 +: WIDTH], bus.ch[WIDTH +: WIDTH]);
        w_diff_ok  = (w_diff_abs <= L_DIFF_TOL);
        w_in_win   = w_chan_ok & w_diff_ok;
        w_new_max  = (w_peak > r_max_dev) ? w_peak : r_max_dev;
        // The cause is taken from the most recent out-of-window cycle, possibly this one.
        if (!w_in_win) begin
            w_tmo_code = w_chan_ok ? 2'd2 : 2'd1;
        end else begin
            w_tmo_code = r_diff_only ? 2'd2 : 2'd1;
        end
    end

    // Check sequencing, counters and registered verdict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_win_cnt   <= 32'd0;
            r_tmo_cnt   <= 32'd0;
            r_settle_at <= 32'd0;
            r_max_dev   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 2'd0;
            r_diff_only <= 1'b0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == S_RUN) begin
                r_fail_code <= 2'd3;
            end else begin
                r_fail_code <= r_fail_code;
            end
        end else if (bus.start) begin
            r_state     <= S_RUN;
            r_target    <= bus.target;
            r_win_cnt   <= 32'd0;
            r_tmo_cnt   <= 32'd0;
            r_settle_at <= 32'd0;
            r_max_dev   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 2'd0;
            r_diff_only <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_max_dev <= w_new_max;
            r_tmo_cnt <= (r_tmo_cnt == L_TMO) ? r_tmo_cnt : r_tmo_cnt + 32'd1;
            if (w_in_win) begin
                r_win_cnt <= (r_win_cnt == L_SET) ? r_win_cnt : r_win_cnt + 32'd1;
                if (r_win_cnt == 32'd0) begin
                    r_settle_at <= r_tmo_cnt;
                end else begin
                    r_settle_at <= r_settle_at;
                end
            end else begin
                r_win_cnt   <= 32'd0;
                r_diff_only <= w_chan_ok;
            end
            // A window completing on the timeout cycle still counts as a pass.
            if (w_in_win && (r_win_cnt == L_SET_M1)) begin
                r_state <= S_PASS;
                r_pass  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else if (r_tmo_cnt == L_TMO_M1) begin
                r_state     <= S_FAIL;
                r_pass      <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_fail_code <= w_tmo_code;
            end else begin
                r_state <= S_RUN;
                r_done  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_code = r_fail_code;
    assign bus.settle_at = r_settle_at;
    assign bus.max_dev   = r_max_dev;

endmodule

// File: tb/tb_converge_monitor.sv
// Directed bench for converge_monitor: a history-based model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_converge_monitor;

    localparam int W     = 16;
    localparam int NCH   = 2;
    localparam int SET   = 64;
    localparam int TMO   = 1000;
    localparam int TOLV  = 250;
    localparam int DTOLV = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    converge_monitor_if #(.WIDTH(W), .NUM_CH(NCH)) bus ();

    converge_monitor #(
        .WIDTH(W), .NUM_CH(NCH), .TOL(TOLV), .DIFF_TOL(DTOLV),
        .SETTLE_CYC(SET), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic set_ch(input int a, input int b);
        bus.ch = {16'(b), 16'(a)};
    endtask

    // Model: keeps the in-window history of the current check and derives the verdict from it
    bit m_active, m_busy, m_done, m_pass;
    int m_fc, m_settle, m_maxdev, m_target;
    bit hist_in[$];
    bit hist_donly[$];

    always @(posedge clk or negedge rst_n) begin : model
        int c0, c1, d0, d1, df, run;
        bit inw, chok;
        if (!rst_n) begin
            m_active = 0; m_busy = 0; m_done = 0; m_pass = 0;
            m_fc = 0; m_settle = 0; m_maxdev = 0; m_target = 0;
            hist_in.delete(); hist_donly.delete();
        end else begin
            m_done = 0;
            if (bus.abort) begin
                if (m_active) m_fc = 3;
                m_active = 0;
                m_busy = 0;
            end else if (bus.start) begin
                m_active = 1; m_busy = 1; m_pass = 0; m_fc = 0;
                m_settle = 0; m_maxdev = 0;
                m_target = int'($signed(bus.target));
                hist_in.delete(); hist_donly.delete();
            end else if (m_active) begin
                c0 = int'($signed(bus.ch[15:0]));
                c1 = int'($signed(bus.ch[31:16]));
                d0 = iabs(c0 - m_target);
                d1 = iabs(c1 - m_target);
                df = iabs(c0 - c1);
                chok = (d0 <= TOLV) && (d1 <= TOLV);
                inw  = chok && (df <= DTOLV);
                hist_in.push_back(inw);
                hist_donly.push_back(chok && !inw);
                if (d0 > m_maxdev) m_maxdev = d0;
                if (d1 > m_maxdev) m_maxdev = d1;
                run = 0;
                for (int k = hist_in.size() - 1; k >= 0 && hist_in[k] && run < SET; k--) run++;
                if (inw && run == 1) m_settle = hist_in.size() - 1;
                if (run >= SET) begin
                    m_active = 0; m_busy = 0; m_done = 1; m_pass = 1;
                end else if (hist_in.size() >= TMO) begin
                    m_active = 0; m_busy = 0; m_done = 1; m_pass = 0;
                    for (int k = hist_in.size() - 1; k >= 0; k--) begin
                        if (!hist_in[k]) begin
                            m_fc = hist_donly[k] ? 2 : 1;
                            break;
                        end
                    end
                end
            end
        end
    end

    // Single compare process: every cycle out of reset, DUT outputs against the model
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            chk("pass", bus.pass, m_pass);
            chk("fail_code", bus.fail_code, m_fc);
            chk("settle_at", bus.settle_at, m_settle);
            chk("max_dev", bus.max_dev, m_maxdev);
        end
    end

    // mode 0: constant channels; 2: step to 200 at run cycle 500; 4: periodic 251 excursions
    task automatic run_check(input int mode, input int max_cyc, output int cyc, output bit got);
        @(negedge clk);
        bus.start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.done) begin
                got = 1'b1;
            end else if (mode == 2 && cyc == 501) begin
                set_ch(200, 200);
            end else if (mode == 4) begin
                if (cyc % (SET - 1) == 0) set_ch(251, 251);
                else set_ch(0, 0);
            end
        end
    endtask

    initial begin
        int cyc;
        bit got;
        bit saw;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.target = '0;
        bus.ch     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_fail_code", bus.fail_code, 0);
        chk("rst_settle_at", bus.settle_at, 0);
        chk("rst_max_dev", bus.max_dev, 0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // 1: quiet channels settle immediately
        set_ch(0, 0);
        run_check(0, 3 * TMO, cyc, got);
        chk("t1_done_seen", got, 1);
        chk("t1_latency", cyc, SET + 1);
        chk("t1_pass", bus.pass, 1);
        chk("t1_settle_at", bus.settle_at, 0);
        chk("t1_max_dev", bus.max_dev, 0);
        repeat (3) @(negedge clk);

        // 2: step from 1000 to 200 at run cycle 500
        set_ch(1000, 1000);
        run_check(2, 3 * TMO, cyc, got);
        chk("t2_done_seen", got, 1);
        chk("t2_latency", cyc, 501 + SET);
        chk("t2_pass", bus.pass, 1);
        chk("t2_settle_at", bus.settle_at, 500);
        chk("t2_max_dev", bus.max_dev, 1000);
        repeat (3) @(negedge clk);

        // 3: channels in tolerance but 10 apart
        set_ch(100, 110);
        run_check(0, 3 * TMO, cyc, got);
        chk("t3_done_seen", got, 1);
        chk("t3_latency", cyc, TMO + 1);
        chk("t3_pass", bus.pass, 0);
        chk("t3_fail_code", bus.fail_code, 2);
        chk("t3_max_dev", bus.max_dev, 110);
        repeat (3) @(negedge clk);

        // 4: window broken just before it can complete
        set_ch(0, 0);
        run_check(4, 3 * TMO, cyc, got);
        chk("t4_done_seen", got, 1);
        chk("t4_latency", cyc, TMO + 1);
        chk("t4_pass", bus.pass, 0);
        chk("t4_fail_code", bus.fail_code, 1);
        chk("t4_max_dev", bus.max_dev, 251);
        set_ch(0, 0);
        repeat (3) @(negedge clk);

        // 5: abort at cycle 10, then start+abort together
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        chk("t5_busy", bus.busy, 0);
        chk("t5_fail_code", bus.fail_code, 3);
        saw = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        if (bus.done) saw = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < SET + 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        chk("t5_idle_no_done", saw, 0);
        chk("t5_fail_code_kept", bus.fail_code, 3);

        // 6: reset mid-check, then a clean restart
        set_ch(300, 300);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_pass", bus.pass, 0);
        chk("t6_fail_code", bus.fail_code, 0);
        chk("t6_settle_at", bus.settle_at, 0);
        chk("t6_max_dev", bus.max_dev, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(0, 0);
        run_check(0, 3 * TMO, cyc, got);
        chk("t6_done_seen", got, 1);
        chk("t6_latency", cyc, SET + 1);
        chk("t6_pass", bus.pass, 1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
